// File: rtl/picosoc_pkg.sv
// Shared constants for the systimer register window: offsets, bit indices, reset values.
// Also holds the byte-lane write merge helper.
package picosoc_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_COUNT  = 5'h04;
  localparam logic [4:0] OFF_CMP    = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_PRESC  = 5'h10;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_AUTORELOAD = 2;
  localparam int STATUS_MATCH    = 0;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/systimer_prescaler.sv
// Tick generator: one tick every presc+1 clocks while en=1; counter parks at 0 when disabled.
// Only instantiated when SYSTIMER_PRESCALER_EN is defined.
module systimer_prescaler (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [15:0] presc,
  output logic        tick
);

  logic [15:0] r_cnt;

  // First tick fires on the first enabled cycle, then the down-counter reloads.
  assign tick = en && (r_cnt == 16'h0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_cnt <= 16'h0;
    else if (!en)
      r_cnt <= 16'h0;
    else if (r_cnt == 16'h0)
      r_cnt <= presc;
    else
      r_cnt <= r_cnt - 16'd1;
  end

endmodule

// File: rtl/systimer.sv
// Memory-mapped system timer on the CPU native bus: free-running/auto-reload COUNT, CMP match, level irq.
// Optional prescaler support is enabled by defining SYSTIMER_PRESCALER_EN.
module systimer
  import picosoc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [2:0]  r_ctrl;
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_match;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_irq;

  logic        w_sel, w_acc, w_wr;
  logic [4:0]  w_off;
  logic        w_wr_ctrl, w_wr_count, w_wr_cmp, w_wr_status, w_wr_presc;
  logic        w_tick, w_hit, w_match_nxt;
  logic [2:0]  w_ctrl_nxt;
  logic [31:0] w_rd, w_presc_rd;
  logic        w_unused;

  assign w_unused = &{1'b0, addr[1:0]};

  // A new transfer is only taken once valid has been seen with ready low.
  assign w_sel = valid && (addr[31:5] == BASE_ADDR[31:5]);
  assign w_acc = w_sel && !r_ready;
  assign w_wr  = w_acc && (wen != 4'b0000);
  assign w_off = {addr[4:2], 2'b00};

  assign w_wr_ctrl   = w_wr && (w_off == OFF_CTRL);
  assign w_wr_count  = w_wr && (w_off == OFF_COUNT);
  assign w_wr_cmp    = w_wr && (w_off == OFF_CMP);
  assign w_wr_status = w_wr && (w_off == OFF_STATUS);
  assign w_wr_presc  = w_wr && (w_off == OFF_PRESC);

`ifdef SYSTIMER_PRESCALER_EN
  logic [15:0] r_presc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc <= 16'h0;
    end else if (w_wr_presc) begin
      if (wen[0]) r_presc[7:0]  <= wdata[7:0];
      if (wen[1]) r_presc[15:8] <= wdata[15:8];
    end
  end

  systimer_prescaler u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .en     (r_ctrl[CTRL_EN]),
    .presc  (r_presc),
    .tick   (w_tick)
  );

  assign w_presc_rd = {16'h0, r_presc};
`else
  logic w_unused_presc;
  assign w_unused_presc = w_wr_presc;
  assign w_tick         = r_ctrl[CTRL_EN];
  assign w_presc_rd     = 32'h0;
`endif

  // A software COUNT write swallows a coincident tick, including its match.
  assign w_hit = w_tick && !w_wr_count && (r_count == r_cmp);

  assign w_ctrl_nxt = (w_wr_ctrl && wen[0]) ? wdata[2:0] : r_ctrl;

  always_comb begin
    w_match_nxt = r_match;
    if (w_wr_status && wen[0] && wdata[STATUS_MATCH]) w_match_nxt = 1'b0;
    if (w_hit)                                        w_match_nxt = 1'b1;
  end

  always_comb begin
    w_rd = 32'h0;
    case (w_off)
      OFF_CTRL:   w_rd = {29'h0, r_ctrl};
      OFF_COUNT:  w_rd = r_count;
      OFF_CMP:    w_rd = r_cmp;
      OFF_STATUS: w_rd = {31'h0, r_match};
      OFF_PRESC:  w_rd = w_presc_rd;
      default:    w_rd = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctrl  <= 3'h0;
      r_count <= 32'h0;
      r_cmp   <= CMP_RST;
      r_match <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
      r_irq   <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl_nxt;
      r_match <= w_match_nxt;
      r_irq   <= w_match_nxt & w_ctrl_nxt[CTRL_IRQ_EN];
      r_ready <= w_acc;
      r_rdata <= w_acc ? w_rd : 32'h0;
      if (w_wr_cmp)
        r_cmp <= byte_merge(r_cmp, wdata, wen);
      if (w_wr_count)
        r_count <= byte_merge(r_count, wdata, wen);
      else if (w_tick)
        r_count <= (w_hit && r_ctrl[CTRL_AUTORELOAD]) ? 32'h0 : r_count + 32'd1;
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;
  assign irq   = r_irq;

endmodule

// File: doc/systimer.md
SYSTIMER -- requirements
Module: systimer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0300_0000, meaning the 32-bit byte base address of the 32-byte register window.
REQ-002 The block SHALL have port clk, input, 1, meaning the single system clock.
REQ-003 The block SHALL have port resetn, input, 1, meaning reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port valid, input, 1, meaning a CPU native-bus request is present.
REQ-005 The block SHALL have port ready, output, 1, meaning a one-cycle transfer-complete pulse.
REQ-006 The block SHALL have port wen, input, 4, meaning byte write strobes; all-zero means read.
REQ-007 The block SHALL have port addr, input, 32, meaning the byte address.
REQ-008 The block SHALL have port wdata, input, 32, meaning write data.
REQ-009 The block SHALL have port rdata, output, 32, meaning read data, valid while ready=1.
REQ-010 The block SHALL have port irq, output, 1, meaning a level timer interrupt, wired to the SoC irq_5 input.

Function
REQ-011 The block SHALL be selected when valid=1 and addr[31:5]==BASE_ADDR[31:5]; otherwise it SHALL ignore the bus and hold ready=0 and rdata=0.
REQ-012 The block SHALL assert ready exactly one cycle after a selected valid, for exactly one cycle, and SHALL NOT re-accept until valid has been sampled with ready=0.
REQ-013 The register map (offset: field) SHALL be as follows.
- 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTORELOAD.
- 0x04 COUNT.
- 0x08 CMP.
- 0x0C STATUS: bit0 MATCH, write-1-to-clear.
- 0x10 PRESC.
- Other offsets SHALL read 0 and ignore writes.
REQ-014 Writes SHALL honour each wen bit per byte lane; RW register writes SHALL take effect on the ready cycle.
REQ-015 COUNT SHALL increment by 1 on every tick while EN=1, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-016 A tick with EN=1 and COUNT==CMP SHALL set MATCH on the next cycle.
REQ-017 On that match tick with AUTORELOAD=1, COUNT SHALL load 0 instead of incrementing.
REQ-018 irq SHALL equal MATCH & IRQ_EN, registered with no combinational path from the bus.
REQ-019 A MATCH set and a software W1C in the same cycle SHALL leave MATCH=1 (set wins).
REQ-020 A software COUNT write in the same cycle as a tick SHALL win, and the tick SHALL be discarded.
REQ-021 Clearing EN SHALL freeze COUNT and reset the prescale counter; setting EN SHALL NOT clear COUNT.

Reset
REQ-022 While resetn=0, the block SHALL force CTRL=0, COUNT=0, CMP=32'hFFFF_FFFF, MATCH=0, PRESC=0, prescale counter=0, ready=0, rdata=0 and irq=0.
REQ-023 A reset during a pending transfer SHALL abort it with no ready pulse and no register write.

Configuration
REQ-024 The macro SYSTIMER_PRESCALER_EN SHALL control prescaler support.
- Defined: PRESC[15:0] is RW with bits [31:16] reading 0; a tick occurs every PRESC+1 clocks while EN=1.
- Undefined: a tick occurs every clock while EN=1; offset 0x10 reads 0 and ignores writes; no prescaler logic is synthesised.

Structure
REQ-025 The shared package picosoc_pkg SHALL hold the register offset constants, the CTRL/STATUS bit-index constants, and the CMP reset value.
REQ-026 Tick generation SHALL live in one sub-module, systimer_prescaler, with inputs clk, resetn, en, presc and output tick, instantiated only under SYSTIMER_PRESCALER_EN.

Verification
REQ-027 Read/write scenario: write CMP=0x1234 then read 0x08 -> rdata=0x0000_1234, with ready pulsing exactly one cycle after valid for each access.
REQ-028 Match/irq scenario: CMP=5, CTRL=0x3 -> MATCH=1 and irq=1 on the cycle after COUNT==5 ticks; COUNT continues 6, 7…; writing STATUS=0x1 drops irq the next cycle.
REQ-029 Auto-reload scenario: CMP=3, CTRL=0x7 -> COUNT sequence 0,1,2,3,0,1…, with MATCH set every 4 ticks.
REQ-030 Wrap scenario: COUNT=0xFFFF_FFFE, CMP=0, EN=1 -> COUNT goes FFFF_FFFF, 0, and MATCH sets after the COUNT==0 tick.
REQ-031 Collision scenario: a W1C of STATUS on the match-set cycle leaves MATCH=1; a COUNT write of 0x10 on a tick cycle gives COUNT=0x10.
REQ-032 Prescaler scenario (macro defined): PRESC=3, EN=1 -> COUNT increments every 4 clocks; wen=4'b0001 to 0x10 with wdata=0xFFFF_FF07 changes only PRESC[7:0].
